// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter sharing one register-bus slave among NoPorts masters.
// The grant is held for a whole transaction, and a watchdog aborts slaves that stall.

package reg_rr_arbiter_pkg;

  // Default bus types, sized for AW=32 and DW=32.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } rsp_t;

endpackage

module reg_rr_arbiter #(
  parameter int unsigned NoPorts       = 2,
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter int unsigned TimeoutCycles = 256,
  parameter type         req_t         = reg_rr_arbiter_pkg::req_t,
  parameter type         rsp_t         = reg_rr_arbiter_pkg::rsp_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  req_t [NoPorts-1:0]         in_req_i,
  output rsp_t [NoPorts-1:0]         in_rsp_o,
  output req_t                       out_req_o,
  input  rsp_t                       out_rsp_i,
  output logic [$clog2(NoPorts)-1:0] grant_o,
  output logic                       busy_o,
  output logic                       timeout_o
);

  localparam int unsigned IdxW = $clog2(NoPorts);
  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  if (NoPorts < 2) begin : g_bad_ports
    $error("reg_rr_arbiter needs at least two ports");
  end
  if ($bits(req_t) != AW + 1 + DW + DW / 8 + 1 || $bits(rsp_t) != DW + 2) begin : g_bad_types
    $error("reg_rr_arbiter bus types do not match AW/DW");
  end

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   gnt_q, gnt_d;
  logic [IdxW-1:0]   rr_q, rr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              found;
  logic [IdxW-1:0]   winner;
  logic [IdxW-1:0]   gnt_inc;
  logic              abort;

  if (TimeoutCycles > 0) begin : g_wdog
    assign abort = (cnt_q == CntW'(TimeoutCycles - 1));
  end else begin : g_no_wdog
    assign abort = 1'b0;
  end

  assign gnt_inc = (gnt_q == IdxW'(NoPorts - 1)) ? '0 : gnt_q + IdxW'(1);

  // Search starts at rr_q and wraps, so the last served master has lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = rr_q;
    for (int k = 0; k < NoPorts; k++) begin
      if (!found && in_req_i[(int'(rr_q) + k) % NoPorts].valid) begin
        found  = 1'b1;
        winner = IdxW'((int'(rr_q) + k) % NoPorts);
      end
    end
  end

  // NOTE: every output and next-state signal gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    out_req_o = '0;
    in_rsp_o  = '0;
    busy_o    = 1'b0;
    timeout_o = 1'b0;
    grant_o   = gnt_q;

    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            gnt_d   = winner;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          busy_o           = 1'b1;
          out_req_o        = in_req_i[gnt_q];
          in_rsp_o[gnt_q]  = out_rsp_i;
          if (out_rsp_i.ready) begin
            state_d = IDLE;
            rr_d    = gnt_inc;
          end else if (!in_req_i[gnt_q].valid) begin
            // Master abandoned the transaction: release without a response or pointer move.
            state_d = IDLE;
          end else if (abort) begin
            out_req_o.valid       = 1'b0;
            in_rsp_o[gnt_q].ready = 1'b1;
            in_rsp_o[gnt_q].error = 1'b1;
            in_rsp_o[gnt_q].rdata = '0;
            timeout_o             = 1'b1;
            state_d               = IDLE;
            rr_d                  = gnt_inc;
          end else if (TimeoutCycles > 0) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Scoreboard bench for reg_rr_arbiter (4 ports, 8-cycle watchdog): directed transactions
// push hand-computed responses; a negedge monitor pops and compares each delivered response.

module tb_reg_rr_arbiter;
  import reg_rr_arbiter_pkg::*;

  localparam int NP = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  req_t [NP-1:0]   in_req;
  rsp_t [NP-1:0]   in_rsp;
  req_t            out_req;
  rsp_t            out_rsp;
  logic [1:0]      grant;
  logic            busy;
  logic            tmo;

  always #5 clk = ~clk;

  reg_rr_arbiter #(
    .NoPorts      (NP),
    .AW           (32),
    .DW           (32),
    .TimeoutCycles(TO),
    .req_t        (req_t),
    .rsp_t        (rsp_t)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .in_req_i (in_req),
    .in_rsp_o (in_rsp),
    .out_req_o(out_req),
    .out_rsp_i(out_rsp),
    .grant_o  (grant),
    .busy_o   (busy),
    .timeout_o(tmo)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        error;
    logic        tmo;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  int          pend[NP];
  logic [31:0] m_addr[NP];
  logic [31:0] m_wdata[NP];
  logic        m_write[NP];
  int          slave_lat;
  logic [31:0] slave_rdata;
  int          cyc;
  int          resp_cyc[$];

  // Masters: hold valid while transactions remain, updated just after each rising edge.
  initial begin
    in_req = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        in_req[p].valid = (pend[p] > 0);
        in_req[p].addr  = m_addr[p];
        in_req[p].wdata = m_wdata[p];
        in_req[p].write = m_write[p];
        in_req[p].wstrb = 4'hF;
      end
    end
  end

  // Slave: ready in the slave_lat-th BUSY cycle; slave_lat=0 stalls forever.
  initial begin
    int bcnt;
    bcnt    = 0;
    out_rsp = '0;
    forever begin
      @(posedge clk);
      #2;
      if (busy) bcnt++;
      else      bcnt = 0;
      out_rsp.ready = (slave_lat != 0) && (bcnt == slave_lat);
      out_rsp.rdata = out_rsp.ready ? slave_rdata : 32'h0;
      out_rsp.error = 1'b0;
    end
  end

  // Monitor: compare every delivered response against the scoreboard head.
  initial begin
    exp_t e;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < NP; p++) begin
        if (in_rsp[p].ready === 1'b1) begin
          if (sb.size() == 0) begin
            check("unexpected_rsp_port", p, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("rsp_port", p, e.port);
            check("rsp_rdata", in_rsp[p].rdata, e.rdata);
            check("rsp_error", 32'(in_rsp[p].error), 32'(e.error));
            check("rsp_timeout_o", 32'(tmo), 32'(e.tmo));
            if (e.tmo) check("abort_out_valid", 32'(out_req.valid), 0);
            else       check("rsp_out_addr", out_req.addr, e.addr);
          end
          resp_cyc.push_back(cyc);
          if (pend[p] > 0) pend[p]--;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (sb.size() != 0 && t < budget) begin
      step(1);
      t++;
    end
    check("drain_pending", sb.size(), 0);
    step(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < NP; p++) pend[p] = 0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic push(input int port, input logic [31:0] rdata, input logic error,
                      input logic t, input logic [31:0] addr);
    exp_t e;
    e.port = port; e.rdata = rdata; e.error = error; e.tmo = t; e.addr = addr;
    sb.push_back(e);
  endtask

  initial begin
    int n0;
    rst         = 1'b1;
    slave_lat   = 0;
    slave_rdata = 32'h0;
    for (int p = 0; p < NP; p++) begin
      pend[p]    = 0;
      m_addr[p]  = 32'h100 + 32'(p) * 4;
      m_wdata[p] = 32'h0;
      m_write[p] = 1'b0;
    end

    // Reset and IDLE values
    step(2);
    check("reset_busy", 32'(busy), 0);
    check("reset_timeout", 32'(tmo), 0);
    check("reset_out_req", 32'(out_req != '0), 0);
    check("reset_in_rsp", 32'(in_rsp != '0), 0);
    check("reset_grant", 32'(grant), 0);
    rst = 1'b0;
    step(1);
    check("idle_busy", 32'(busy), 0);
    check("idle_out_req", 32'(out_req != '0), 0);

    // Single master: port 2 writes 0x10, slave ready in 2nd BUSY cycle
    slave_lat   = 2;
    slave_rdata = 32'h0;
    m_addr[2]   = 32'h10;
    m_wdata[2]  = 32'hDEADBEEF;
    m_write[2]  = 1'b1;
    push(2, 32'h0, 1'b0, 1'b0, 32'h10);
    n0      = resp_cyc.size();
    pend[2] = 1;
    step(1);
    check("t1_busy_before_grant", 32'(busy), 0);
    step(1);
    check("t1_busy", 32'(busy), 1);
    check("t1_grant", 32'(grant), 2);
    check("t1_out_valid", 32'(out_req.valid), 1);
    check("t1_out_addr", out_req.addr, 32'h10);
    check("t1_out_wdata", out_req.wdata, 32'hDEADBEEF);
    check("t1_out_write", 32'(out_req.write), 1);
    check("t1_other_rsp", 32'(in_rsp[0] != '0 || in_rsp[1] != '0 || in_rsp[3] != '0), 0);
    step(2);
    check("t1_idle_after", 32'(busy), 0);
    check("t1_rr_q", 32'(dut.rr_q), 3);
    check("t1_rsp_count", resp_cyc.size() - n0, 1);
    check("t1_sb_empty", sb.size(), 0);
    m_write[2] = 1'b0;

    // Fairness: ports 0,1,3 two reads each, immediate slave
    do_reset();
    slave_lat   = 1;
    slave_rdata = 32'h11;
    for (int r = 0; r < 2; r++) begin
      push(0, 32'h11, 1'b0, 1'b0, m_addr[0]);
      push(1, 32'h11, 1'b0, 1'b0, m_addr[1]);
      push(3, 32'h11, 1'b0, 1'b0, m_addr[3]);
    end
    n0 = resp_cyc.size();
    pend[0] = 2; pend[1] = 2; pend[3] = 2;
    wait_drain(40);
    check("fair_rsp_count", resp_cyc.size() - n0, 6);
    for (int i = n0 + 1; i < resp_cyc.size(); i++)
      check("fair_spacing", resp_cyc[i] - resp_cyc[i-1], 2);

    // Grant lock: port 1 arrives while port 0 is stalled
    do_reset();
    slave_lat   = 6;
    slave_rdata = 32'h22;
    push(0, 32'h22, 1'b0, 1'b0, m_addr[0]);
    push(1, 32'h22, 1'b0, 1'b0, m_addr[1]);
    pend[0] = 1;
    step(2);
    pend[1] = 1;
    for (int i = 0; i < 5; i++) begin
      check("lock_grant", 32'(grant), 0);
      check("lock_busy", 32'(busy), 1);
      step(1);
    end
    wait_drain(40);

    // Watchdog abort on port 1 read, slave never ready
    slave_lat   = 0;
    m_addr[1]   = 32'h200;
    push(1, 32'h0, 1'b1, 1'b1, 32'h200);
    pend[1] = 1;
    step(2);
    check("to_busy", 32'(busy), 1);
    step(6);
    check("to_no_early_abort", 32'(tmo), 0);
    check("to_busy_7th", 32'(busy), 1);
    step(1);
    step(1);
    check("to_idle_after", 32'(busy), 0);
    check("to_pulse_gone", 32'(tmo), 0);
    check("to_rr_q", 32'(dut.rr_q), 2);
    check("to_sb_empty", sb.size(), 0);

    // Ready coincides with the watchdog limit: ready wins
    slave_lat   = TO;
    slave_rdata = 32'h5A;
    push(1, 32'h5A, 1'b0, 1'b0, 32'h200);
    pend[1] = 1;
    wait_drain(20);

    // Reset during a stalled read; port 1 waits behind port 3
    slave_lat   = 0;
    m_addr[3]   = 32'h300;
    pend[3]     = 1;
    step(2);
    check("rst_grant_before", 32'(grant), 3);
    pend[1] = 1;
    step(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_out_valid", 32'(out_req.valid), 0);
    check("rst_rr_q", 32'(dut.rr_q), 0);
    slave_lat   = 1;
    slave_rdata = 32'h33;
    push(1, 32'h33, 1'b0, 1'b0, m_addr[1]);
    push(3, 32'h33, 1'b0, 1'b0, 32'h300);
    step(1);
    check("rst_first_grant", 32'(grant), 1);
    wait_drain(20);

    // Master drops valid mid-transaction: release, no response, pointer kept
    slave_lat = 0;
    n0        = resp_cyc.size();
    pend[2]   = 1;
    step(2);
    check("drop_grant", 32'(grant), 2);
    pend[2] = 0;
    step(1);
    check("drop_out_valid", 32'(out_req.valid), 0);
    step(1);
    check("drop_idle", 32'(busy), 0);
    check("drop_rr_q", 32'(dut.rr_q), 0);
    check("drop_no_rsp", resp_cyc.size() - n0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
